// File: rtl/param_deserializer.sv
// rtl/param_deserializer.sv - serial-to-parallel converter with sync-word alignment
module param_deserializer #(
  parameter int               WIDTH     = 8,
  parameter bit               LSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(8'hA5)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             realign,
  output logic [WIDTH-1:0] parallel_data,
  output logic             out_valid,
  output logic             locked,
  output logic             sync_seen
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sr, sr_next, shifted, data_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             ov_next, ss_next;

  always_comb begin
    if (LSB_FIRST) shifted = {din, sr[WIDTH-1:1]};
    else           shifted = {sr[WIDTH-2:0], din};
  end

  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    data_next  = parallel_data;
    ov_next    = 1'b0;
    ss_next    = 1'b0;
    if (din_valid) begin
      sr_next = shifted;
      if (state == HUNT) begin
        if (shifted == SYNC_WORD) begin
          state_next = LOCKED;
          cnt_next   = '0;
          ss_next    = 1'b1;
        end
      end else if (cnt == LAST) begin
        data_next = shifted;
        ov_next   = 1'b1;
        cnt_next  = '0;
        ss_next   = (shifted == SYNC_WORD);
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
    // realign wins over a word completing on the same edge; sr keeps its bits
    if (realign) begin
      state_next = HUNT;
      cnt_next   = '0;
      data_next  = parallel_data;
      ov_next    = 1'b0;
      ss_next    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      sr            <= '0;
      cnt           <= '0;
      parallel_data <= '0;
      out_valid     <= 1'b0;
      sync_seen     <= 1'b0;
    end else begin
      state         <= state_next;
      sr            <= sr_next;
      cnt           <= cnt_next;
      parallel_data <= data_next;
      out_valid     <= ov_next;
      sync_seen     <= ss_next;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: doc/param_deserializer.md
Name: param_deserializer

Overview:
Parametrised serial-to-parallel converter; successor to the fixed 8-bit deserializer. Adds configurable word width, bit order, a per-bit valid qualifier, and word alignment by hunting for a sync word. It sits at the receive end of the SerDes link and feeds recovered words to downstream framing logic with a one-cycle valid strobe.

Parameters:
WIDTH, 8, parallel word width in bits (legal range 2..32).
LSB_FIRST, 1, 1: first received bit lands in parallel_data[0]; 0: first received bit lands in parallel_data[WIDTH-1].
SYNC_WORD, 8'hA5 (WIDTH bits), alignment pattern searched in HUNT state.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
din  input  1  serial data bit.
din_valid  input  1  din is sampled only on edges where this is 1.
realign  input  1  synchronous; forces return to HUNT.
parallel_data  output  WIDTH  last completed aligned word.
out_valid  output  1  one-cycle pulse: parallel_data updated.
locked  output  1  1 while in LOCKED state.
sync_seen  output  1  one-cycle pulse when a word equal to SYNC_WORD is detected, in either state.

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n=0 immediately clears all state regardless of clk.
- Reset values: parallel_data=0, out_valid=0, locked=0, sync_seen=0, shift register=0, bit counter=0, state=HUNT.
- Shift register sr (WIDTH bits) updates only on edges with din_valid=1.
  - LSB_FIRST=1: sr_next = {din, sr[WIDTH-1:1]}.
  - LSB_FIRST=0: sr_next = {sr[WIDTH-2:0], din}.
- Edges with din_valid=0 change nothing except that the out_valid and sync_seen pulses are cleared.
- State HUNT:
  - Each valid bit, compare sr_next with SYNC_WORD.
  - On a match: next state is LOCKED, bit counter is 0, and sync_seen=1 for one cycle.
  - The sync word itself is never emitted on parallel_data.
  - out_valid stays 0 throughout HUNT.
- State LOCKED:
  - Bit counter (width clog2(WIDTH)) increments on each valid bit.
  - On the valid bit where counter==WIDTH-1: parallel_data<=sr_next, out_valid=1 for exactly one cycle, counter wraps to 0.
  - Latency: out_valid and the new parallel_data are visible in the cycle after the edge that accepted the last bit.
  - If a completed word equals SYNC_WORD, it is still emitted (out_valid=1) and sync_seen=1 in the same cycle. Lock is unchanged.
  - Bit matches at non-word boundaries are ignored in LOCKED.
- realign=1 on an edge:
  - State goes to HUNT, locked=0, counter=0, and out_valid=0 on that edge.
  - sr is not cleared; the search resumes with the next valid bit.
  - realign has priority over word completion on the same edge.
- locked is registered: 1 from the cycle after the matching edge until realign or reset.
- parallel_data holds its value between completions and across realign.
- Reset asserted mid-word discards the partial word. After release, the block is in HUNT and requires a full sync word before any output.
- A back-to-back sync word in LOCKED with zero gap bits is legal; sustained din_valid=1 yields one word every WIDTH cycles.

Test Plan:
- Defaults, din_valid=1: send 0xA5 LSB-first (1,0,1,0,0,1,0,1) then 0x3C LSB-first -> sync_seen pulse and locked=1 after 8th bit; out_valid single pulse 8 bits later with parallel_data=0x3C; no out_valid for 0xA5.
- Same stream but din_valid toggled 1/0 every cycle -> identical parallel_data=0x3C and one out_valid; no change on din_valid=0 cycles.
- LSB_FIRST=0, SYNC_WORD=0xA5: send 0xA5 MSB-first then 0x81 MSB-first -> parallel_data=0x81; then 0xA5 again -> out_valid with 0xA5 and sync_seen in the same cycle, locked stays 1.
- Locked, 4 bits into a word, assert rst_n=0 between clock edges -> all outputs 0 immediately; subsequent 0x3C without sync -> no out_valid, locked=0.
- Locked, assert realign on the edge of the 8th bit of a word -> no out_valid, locked=0 next cycle, parallel_data keeps its prior value; relock on the next 0xA5.
- WIDTH=12, SYNC_WORD=12'hF0A, LSB_FIRST=1: random 5-bit preamble, then sync, then 12'h5C3 -> parallel_data=12'h5C3, one out_valid.
